bootrom_ctrl: RTL
=================

Name: bootrom_ctrl

Overview:
Parametrised boot ROM slave on the core's req/gnt/rvalid data bus. It is the successor to the fixed 5-word boot stub and adds configurable width, depth, base address and wait states. It also adds error responses and a sticky "hide" latch so software can lock the ROM out after boot. It sits on the system interconnect at the reset-vector region, and its contents come from a package-level image.

Parameters:
DataWidth, 32, bus data width in bits; 32 or 64.
Depth, 16, number of ROM words; >=1, need not be a power of two.
BaseAddr, 32'h0000_0000, byte address of word 0; aligned to Depth*DataWidth/8 rounded up to a power of two.
WaitStates, 0, extra cycles between grant and response; 0..15.
InitImage, bootrom_pkg::DefaultImage, Depth x DataWidth contents; word i is at BaseAddr + i*DataWidth/8.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
req_i  in  1  request valid.
we_i  in  1  write enable; always errors.
be_i  in  DataWidth/8  byte enables; ignored for reads.
addr_i  in  32  byte address.
data_i  in  DataWidth  write data; ignored.
gnt_o  out  1  request accepted this cycle.
rvalid_o  out  1  response valid, one-cycle pulse.
err_o  out  1  response is an error; qualified by rvalid_o.
data_o  out  DataWidth  read data; qualified by rvalid_o.
hide_i  in  1  pulse; permanently hides the ROM until reset.
hidden_o  out  1  hide latch status.

Behaviour:
- Reset values: gnt_o is combinational; rvalid_o=0, err_o=0, data_o=0, hidden_o=0, FSM=IDLE, wait counter=0.
- Clock and reset: clock clk_i; reset rst_ni, asynchronous, active-low.
- Grant: gnt_o = req_i && state==IDLE. A grant at cycle T produces rvalid_o at cycle T+1+WaitStates, high for exactly one cycle.
- At most one transaction is outstanding.
  - WaitStates=0: back-to-back grants every cycle; full throughput.
  - WaitStates>0: gnt_o is low during cycles T+1..T+WaitStates. gnt_o may be high again in the cycle rvalid_o is high.
- FSM:
  - IDLE: on a grant with WaitStates=0, stay in IDLE and register the response for next cycle. On a grant with WaitStates>0, load cnt=WaitStates and go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt==1, go to IDLE and assert rvalid_o the next cycle.
- All request fields (we_i, addr_i, decoded index, error cause) are captured at grant. Inputs changing during WAIT have no effect.
- Decode of the address captured at grant:
  - off = addr_i - BaseAddr, 32-bit unsigned, so wrap below BaseAddr lands out of range.
  - idx = off >> log2(DataWidth/8).
- Error conditions; any one gives err_o=1 and data_o=0 in the response cycle:
  - we_i=1, regardless of be_i;
  - idx >= Depth;
  - off[log2(DataWidth/8)-1:0] != 0 (misaligned);
  - hidden_o=1 at grant.
- A successful read gives err_o=0 and data_o=InitImage[idx].
- data_o is registered and holds its last response value until the next response. err_o is cleared in any cycle without rvalid_o.
- Hide latch:
  - hide_i=1 sets hidden_q at the next edge. It is sticky and cleared only by rst_ni.
  - A request granted in the same cycle as hide_i completes normally. Requests granted afterwards error.
  - A transaction already in WAIT when hide_i rises completes normally.
- Reset mid-transaction: the pending response is dropped, no rvalid_o follows, and the hide latch clears.
- No writes ever alter contents; the block contains no storage other than flops.

Decomposition:
- bootrom_pkg holds:
  - DefaultImage: zero-padded boot stub (lui a1,0x2c00; sw x0,0(a1); lui a0,0x2000; jalr a0; j .);
  - err_cause_e enum {ERR_NONE, ERR_WRITE, ERR_RANGE, ERR_ALIGN, ERR_HIDDEN}, used internally and for assertions;
  - helper function rom_decode(addr, base, depth, bytes) returning idx and cause.
- No sub-module is needed; FSM, counter and decode live in bootrom_ctrl. The image is elaborated as a constant, which synthesizes to logic.

Test Plan:
- WaitStates=0, back-to-back reads of 0x0, 0x4, 0x8 on cycles 1..3 -> gnt_o high all three cycles; rvalid_o on cycles 2..4 with data 0x02c005b7, 0x0005a023, 0x02000537; err_o=0.
- WaitStates=3, read 0x10 granted at T, req_i held -> gnt_o low T+1..T+3; rvalid_o at T+4 with data 0x0000006f; second grant at T+4.
- Errors, one request each:
  - write to 0x0 -> err_o=1, data_o=0;
  - read 0x40 with Depth=16 -> err;
  - read 0x2 -> misaligned err;
  - BaseAddr=0x1000, read 0xFFC -> range err (wrap).
- hide_i pulsed in the same cycle as the grant of a read of 0x4 -> that response returns 0x0005a023, err_o=0. Next read of 0x4 -> err_o=1, data_o=0, hidden_o=1 until reset.
- WaitStates=2, assert rst_ni low one cycle after grant -> no rvalid_o ever appears for it; after reset, read 0x0 returns 0x02c005b7 and hidden_o=0.
- DataWidth=64, Depth=3, reads 0x0, 0x10, 0x18 -> words 0 and 2 returned; 0x18 gives err_o=1 (range).

Source files
------------

// File: rtl/bootrom_pkg.sv
// Shared types, default boot image and address decode for the boot ROM slave.
package bootrom_pkg;

  // Wide enough for any image up to 128 x 64-bit words; larger ROMs must supply InitImage.
  localparam int unsigned ImageMaxBits = 8192;

  // Boot stub: lui a1,0x2c00; sw x0,0(a1); lui a0,0x2000; jalr a0; j .
  localparam logic [ImageMaxBits-1:0] DefaultImage = ImageMaxBits'({
    32'h0000_006f, 32'h0005_0067, 32'h0200_0537, 32'h0005_a023, 32'h02c0_05b7
  });

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_WRITE,
    ERR_RANGE,
    ERR_ALIGN,
    ERR_HIDDEN
  } err_cause_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic [31:0] idx;
    err_cause_e  cause;
  } decode_t;

  // Offset wraps modulo 2^32, so addresses below base fall out of range.
  function automatic decode_t rom_decode(logic [31:0] addr, logic [31:0] base,
                                         int unsigned depth, int unsigned bytes);
    decode_t     d;
    logic [31:0] off;
    off     = addr - base;
    d.idx   = off >> $clog2(bytes);
    d.cause = ERR_NONE;
    if ((off & (bytes - 32'd1)) != 32'd0) begin
      d.cause = ERR_ALIGN;
    end else if (d.idx >= depth) begin
      d.cause = ERR_RANGE;
    end
    return d;
  endfunction

endpackage

// File: rtl/bootrom_ctrl.sv
// Boot ROM slave on the req/gnt/rvalid bus with wait states, error responses
// and a sticky hide latch that locks the ROM out until reset.
module bootrom_ctrl
  import bootrom_pkg::*;
#(
  parameter int unsigned                DataWidth  = 32,
  parameter int unsigned                Depth      = 16,
  parameter logic [31:0]                BaseAddr   = 32'h0000_0000,
  parameter int unsigned                WaitStates = 0,
  parameter logic [Depth*DataWidth-1:0] InitImage  = DefaultImage[Depth*DataWidth-1:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [31:0]            addr_i,
  input  logic [DataWidth-1:0]   data_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic                   err_o,
  output logic [DataWidth-1:0]   data_o,
  input  logic                   hide_i,
  output logic                   hidden_o
);

  localparam int unsigned Bytes   = DataWidth / 8;
  localparam int unsigned IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [3:0]  CntInit = 4'(WaitStates);

  logic [DataWidth-1:0] rom_w [Depth];

  for (genvar i = 0; i < Depth; i++) begin : g_rom
    assign rom_w[i] = InitImage[i*DataWidth +: DataWidth];
  end

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [IdxW-1:0]      pend_idx_q;
  err_cause_e           pend_cause_q;
  logic                 hidden_q;
  logic                 rvalid_q;
  logic                 err_q;
  logic [DataWidth-1:0] data_q;

  decode_t              dec;
  err_cause_e           req_cause;
  err_cause_e           sel_cause;
  logic [IdxW-1:0]      sel_idx;
  logic [DataWidth-1:0] rsp_data;

  assign gnt_o = req_i && (state_q == ST_IDLE);

  // Write outranks hidden, which outranks the address-derived causes.
  always_comb begin
    dec       = rom_decode(addr_i, BaseAddr, Depth, Bytes);
    req_cause = dec.cause;
    if (hidden_q) req_cause = ERR_HIDDEN;
    if (we_i)     req_cause = ERR_WRITE;
  end

  // In IDLE the response comes straight from the live request; in WAIT from the capture.
  always_comb begin
    sel_cause = pend_cause_q;
    sel_idx   = pend_idx_q;
    if (state_q == ST_IDLE) begin
      sel_cause = req_cause;
      sel_idx   = dec.idx[IdxW-1:0];
    end
    rsp_data = '0;
    if (sel_cause == ERR_NONE) rsp_data = rom_w[sel_idx];
  end

  // Request capture at grant (data path, no reset needed)
  always_ff @(posedge clk_i) begin
    if (gnt_o) begin
      pend_idx_q   <= dec.idx[IdxW-1:0];
      pend_cause_q <= req_cause;
    end
  end

  // Control FSM, wait counter, hide latch and registered response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hidden_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      hidden_q <= hidden_q | hide_i;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_o) begin
            if (WaitStates == 0) begin
              rvalid_q <= 1'b1;
              err_q    <= (sel_cause != ERR_NONE);
              data_q   <= rsp_data;
            end else begin
              cnt_q   <= CntInit;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b1;
            err_q    <= (sel_cause != ERR_NONE);
            data_q   <= rsp_data;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign data_o   = data_q;
  assign hidden_o = hidden_q;

  logic unused_ok;
  assign unused_ok = ^{be_i, data_i, dec.idx};

  a_err_qualified: assert property (@(posedge clk_i) disable iff (!rst_ni) err_o |-> rvalid_o);

endmodule
